// File: rtl/tdm_demux4_pkg.sv
// Shared types for the 4-slot TDM demultiplexer: FSM states and slot indexing.
package tdm_demux4_pkg;

    localparam int NSLOT = 4;

    typedef logic [$clog2(NSLOT)-1:0] slot_idx_t;

    localparam slot_idx_t SLOT_FIRST = slot_idx_t'(0);
    localparam slot_idx_t SLOT_NEXT  = slot_idx_t'(1);
    localparam slot_idx_t SLOT_LAST  = slot_idx_t'(NSLOT - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4.sv
// Purpose: reassembles sof-framed serial slot words into one parallel 4-slot vector.
// Latency: dout/dout_valid update on the same edge that accepts the slot-3 word.
// Backpressure: none; every din_valid word is consumed (dropped while hunting for sof).
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   sof,
    input  logic                   err_clr,
    output logic [NSLOT*WIDTH-1:0] dout,
    output logic                   dout_valid,
    output slot_idx_t              slot,
    output logic                   frame_err
);

    state_t                 state;
    state_t                 state_nxt;
    slot_idx_t              slot_nxt;
    logic [NSLOT*WIDTH-1:0] stage;
    logic [NSLOT*WIDTH-1:0] stage_nxt;
    logic [NSLOT*WIDTH-1:0] dout_nxt;
    logic                   dout_valid_nxt;
    logic                   frame_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            slot       <= SLOT_FIRST;
            stage      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot       <= slot_nxt;
            stage      <= stage_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        slot_nxt       = slot;
        stage_nxt      = stage;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        // An early sof below overrides a same-cycle clear.
        frame_err_nxt  = err_clr ? 1'b0 : frame_err;

        case (state)
            HUNT: begin
                if (din_valid && sof) begin
                    stage_nxt              = '0;
                    stage_nxt[WIDTH-1:0]   = din;
                    slot_nxt               = SLOT_NEXT;
                    state_nxt              = COLLECT;
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    if (sof) begin
                        frame_err_nxt        = 1'b1;
                        stage_nxt            = '0;
                        stage_nxt[WIDTH-1:0] = din;
                        slot_nxt             = SLOT_NEXT;
                    end else begin
                        stage_nxt[int'(slot)*WIDTH +: WIDTH] = din;
                        if (slot == SLOT_LAST) begin
                            dout_nxt       = stage_nxt;
                            dout_valid_nxt = 1'b1;
                            slot_nxt       = SLOT_FIRST;
                            state_nxt      = HUNT;
                        end else begin
                            slot_nxt = slot + slot_idx_t'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                slot_nxt  = SLOT_FIRST;
            end
        endcase
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: expected frames queued at stimulus time, popped on dout_valid.
module tb_tdm_demux4;

    localparam int W = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           sof = 1'b0;
    logic           err_clr = 1'b0;
    logic [4*W-1:0] dout;
    logic           dout_valid;
    logic [1:0]     slot;
    logic           frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int vld_cnt = 0;
    logic [4*W-1:0] sb[$];
    logic [4*W-1:0] last_dout = '0;
    logic           prev_vld = 1'b0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard/monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_dout", 32'(dout), 32'(0));
            chk("rst_vld", 32'(dout_valid), 32'(0));
            last_dout = '0;
        end else if (dout_valid) begin
            vld_cnt++;
            chk("pulse_width", 32'(prev_vld), 32'(0));
            chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) chk("dout", 32'(dout), 32'(sb.pop_front()));
            last_dout = dout;
        end else begin
            chk("dout_hold", 32'(dout), 32'(last_dout));
        end
        prev_vld = dout_valid;
    end

    task automatic step(input logic v, input logic s, input logic [W-1:0] d, input logic c);
        @(posedge clk);
        #1;
        din_valid = v;
        sof       = s;
        din       = d;
        err_clr   = c;
    endtask

    task automatic word(input logic s, input logic [W-1:0] d);
        step(1'b1, s, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Reset state
        idle(2);
        chk("reset_slot", 32'(slot), 32'(0));
        chk("reset_err", 32'(frame_err), 32'(0));
        chk("reset_dout", 32'(dout), 32'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Frame 1,0,1,0 then 0,1,0,1 back to back
        word(1'b1, 1'b1); word(1'b0, 1'b0); word(1'b0, 1'b1);
        sb.push_back(4'b0101);
        word(1'b0, 1'b0);
        word(1'b1, 1'b0);
        chk("f1_slot", 32'(slot), 32'(0));
        chk("f1_err", 32'(frame_err), 32'(0));
        word(1'b0, 1'b1); word(1'b0, 1'b0);
        sb.push_back(4'b1010);
        word(1'b0, 1'b1);
        idle(1);
        chk("f1_vld_cnt", 32'(vld_cnt), 32'(1));
        idle(1);
        chk("f2_vld_cnt", 32'(vld_cnt), 32'(2));
        chk("f2_slot", 32'(slot), 32'(0));
        chk("f2_err", 32'(frame_err), 32'(0));

        // Early sof: partial 1,1 discarded, restart with 0,0,0,0
        word(1'b1, 1'b1); word(1'b0, 1'b1); word(1'b1, 1'b0);
        idle(1);
        chk("early_err", 32'(frame_err), 32'(1));
        chk("early_slot", 32'(slot), 32'(1));
        chk("early_vld_cnt", 32'(vld_cnt), 32'(2));
        word(1'b0, 1'b0); word(1'b0, 1'b0);
        sb.push_back(4'b0000);
        word(1'b0, 1'b0);
        idle(2);
        chk("early_frame_cnt", 32'(vld_cnt), 32'(3));
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("err_clr", 32'(frame_err), 32'(0));

        // Words in HUNT ignored; gapped frame 1,0,0,1
        word(1'b0, 1'b1); word(1'b0, 1'b1); word(1'b0, 1'b1);
        idle(1);
        chk("hunt_slot", 32'(slot), 32'(0));
        word(1'b1, 1'b1); idle(3);
        chk("gap_slot_hold", 32'(slot), 32'(1));
        word(1'b0, 1'b0); idle(3);
        word(1'b0, 1'b0); idle(3);
        chk("gap_slot3", 32'(slot), 32'(3));
        chk("gap_no_early_vld", 32'(vld_cnt), 32'(3));
        sb.push_back(4'b1001);
        word(1'b0, 1'b1);
        idle(2);
        chk("gap_vld_cnt", 32'(vld_cnt), 32'(4));
        chk("gap_err", 32'(frame_err), 32'(0));

        // Reset mid-frame, then frame 0,0,1,1
        word(1'b1, 1'b1); word(1'b0, 1'b1);
        idle(1);
        chk("pre_rst_slot", 32'(slot), 32'(2));
        @(posedge clk); #1 rst = 1'b1;
        idle(2);
        chk("mid_rst_slot", 32'(slot), 32'(0));
        chk("mid_rst_dout", 32'(dout), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        word(1'b1, 1'b0); word(1'b0, 1'b0); word(1'b0, 1'b1);
        sb.push_back(4'b1100);
        word(1'b0, 1'b1);
        idle(2);
        chk("post_rst_vld_cnt", 32'(vld_cnt), 32'(5));

        // Same-cycle err_clr and early sof: set wins
        word(1'b1, 1'b0); word(1'b1, 1'b0);
        idle(1);
        chk("sticky_set", 32'(frame_err), 32'(1));
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("set_beats_clr", 32'(frame_err), 32'(1));
        chk("set_beats_clr_slot", 32'(slot), 32'(1));
        word(1'b0, 1'b1); word(1'b0, 1'b1);
        sb.push_back(4'b1110);
        word(1'b0, 1'b1);
        idle(2);
        chk("sticky_frame_cnt", 32'(vld_cnt), 32'(6));
        chk("sticky_still_set", 32'(frame_err), 32'(1));
        step(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("final_clr", 32'(frame_err), 32'(0));
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
